pll_lock_ctrl: RTL and testbench
================================

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 256: cycles spent in LOAD with load_freq held high.
REQ-002 Parameter LOCK_CNT, default 64: consecutive error-free cycles needed to declare lock.
REQ-003 Parameter TRACK_TMO, default 4096: maximum cycles in TRACK before a retry.
REQ-004 Parameter MAX_RETRY, default 3: retries allowed before FAULT.
REQ-005 Parameter UNLOCK_CNT, default 4: consecutive error cycles that drop lock (used only with LOCK_HYST_EN).
REQ-006 clk  in  1  system clock; all state updates on its rising edge.
REQ-007 nrst  in  1  asynchronous, active-low reset.
REQ-008 swiptAlive  in  1  link-alive qualifier from the heartbeat block.
REQ-009 adc_comp  in  1  comparator output from the ADC compare block.
REQ-010 pll_err  in  2  PLL phase-detector error; bit0 is the feedback sample, bit1 is the phase-slip flag.
REQ-011 load_freq  out  1  high means the PLL loads its default frequency step.
REQ-012 pll_in  out  1  registered PLL input sample.
REQ-013 locked  out  1  PLL lock indicator.
REQ-014 fault  out  1  sticky lock-failure flag.
REQ-015 state  out  3  current FSM state code.

Function
REQ-016 The FSM SHALL have these states and codes: IDLE=0, LOAD=1, TRACK=2, LOCKED=3, FAULT=4.
REQ-017 IDLE SHALL drive load_freq=1 and SHALL move to LOAD on the first cycle swiptAlive=1.
REQ-018 LOAD SHALL drive load_freq=1, SHALL count SETTLE_CYC cycles, and SHALL then move to TRACK with the counter cleared.
REQ-019 TRACK and LOCKED SHALL drive load_freq=0; IDLE, LOAD and FAULT SHALL drive load_freq=1.
REQ-020 pll_in SHALL be registered every cycle: pll_err[0] in TRACK and LOCKED, adc_comp in all other states; latency is 1 cycle.
REQ-021 In TRACK, each cycle with pll_err==2'b00 SHALL increment the lock counter, and any nonzero pll_err SHALL clear it.
REQ-022 When the lock counter reaches LOCK_CNT, the FSM SHALL enter LOCKED and set locked=1 in the same cycle as the state change.
REQ-023 In TRACK, after TRACK_TMO cycles without lock, retry_cnt SHALL increment and the FSM SHALL return to LOAD.
REQ-024 If retry_cnt is already MAX_RETRY when that timeout occurs, the FSM SHALL enter FAULT and set fault=1.
REQ-025 If timeout and lock occur in the same cycle, lock SHALL win.
REQ-026 In LOCKED, pll_err[1]=1 SHALL drop the FSM to TRACK with locked=0 and the lock counter cleared; retry_cnt is unchanged.
REQ-027 retry_cnt SHALL clear on entry to LOCKED and on entry to IDLE.
REQ-028 FAULT SHALL hold until swiptAlive=0; fault SHALL stay set until the FSM re-enters LOAD.
REQ-029 swiptAlive=0 in any state SHALL force IDLE on the next edge with locked=0; this overrides every other transition.
REQ-030 All counters SHALL saturate and never wrap; counter widths are sized with $clog2 of their limits.

Reset
REQ-031 While nrst=0, the outputs SHALL be state=IDLE, load_freq=1, pll_in=0, locked=0 and fault=0, with all counters at 0.
REQ-032 Reset asserted mid-operation SHALL take effect immediately (asynchronous assert); the FSM resumes from IDLE after release.

Configuration
REQ-033 With macro LOCK_HYST_EN defined, LOCKED SHALL leave only after UNLOCK_CNT consecutive cycles with pll_err[1]=1; any cycle without it SHALL clear that count.
REQ-034 Without LOCK_HYST_EN, a single pll_err[1]=1 cycle SHALL leave LOCKED, and UNLOCK_CNT SHALL be unused.

Verification
REQ-035 Release nrst with swiptAlive=1 and pll_err=0 -> state goes IDLE, LOAD, TRACK; locked rises exactly 1+256+64 cycles after release (±1).
REQ-036 In TRACK, inject pll_err=2'b01 at count 63 -> lock counter clears; locked rises 64 cycles after the error.
REQ-037 Hold pll_err=2'b01 permanently -> 4 LOAD/TRACK attempts, then fault=1 and state=4; drop swiptAlive -> IDLE, fault still 1 until LOAD.
REQ-038 In LOCKED, pulse pll_err[1] for 1 cycle -> locked=0 next edge without macro; locked stays 1 with LOCK_HYST_EN; 4 cycles of pll_err[1] -> locked=0 with LOCK_HYST_EN.
REQ-039 Deassert swiptAlive in LOCKED, and separately assert nrst in TRACK -> IDLE and locked=0 next edge (immediately for nrst); pll_in follows adc_comp with 1-cycle latency.

Source files
------------

// File: rtl/pll_lock_ctrl_if.sv
// pll_lock_ctrl_if: status/control bundle between the PLL supervisor and its peers.
// Signals: swiptAlive, adc_comp, pll_err -> controller; load_freq, pll_in, locked, fault, state <- controller.
interface pll_lock_ctrl_if;
   logic       swiptAlive;
   logic       adc_comp;
   logic [1:0] pll_err;
   logic       load_freq;
   logic       pll_in;
   logic       locked;
   logic       fault;
   logic [2:0] state;

   modport master (
      output swiptAlive, adc_comp, pll_err,
      input  load_freq, pll_in, locked, fault, state
   );

   modport slave (
      input  swiptAlive, adc_comp, pll_err,
      output load_freq, pll_in, locked, fault, state
   );
endinterface

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL acquisition supervisor (IDLE -> LOAD -> TRACK -> LOCKED, FAULT after retries).
// Ports: clk, nrst (async active-low), bus (slave modport of pll_lock_ctrl_if).
//   in : swiptAlive link qualifier, adc_comp comparator, pll_err {slip, feedback}
//   out: load_freq, pll_in (registered sample), locked, fault (sticky), state code
// Option: define LOCK_HYST_EN to leave LOCKED only after UNLOCK_CNT consecutive slips.
module pll_lock_ctrl #(
   parameter int SETTLE_CYC = 256,
   parameter int LOCK_CNT   = 64,
   parameter int TRACK_TMO  = 4096,
   parameter int MAX_RETRY  = 3,
   parameter int UNLOCK_CNT = 4
) (
   input  logic           clk,
   input  logic           nrst,
   pll_lock_ctrl_if.slave bus
);

   localparam int SW = ($clog2(SETTLE_CYC + 1) > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam int LW = ($clog2(LOCK_CNT + 1) > 0) ? $clog2(LOCK_CNT + 1) : 1;
   localparam int TW = ($clog2(TRACK_TMO + 1) > 0) ? $clog2(TRACK_TMO + 1) : 1;
   localparam int RW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_CNT - 1);
   localparam logic [LW-1:0] LOCK_MAX    = LW'(LOCK_CNT);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TRACK_TMO - 1);
   localparam logic [TW-1:0] TMO_MAX     = TW'(TRACK_TMO);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      TRACK  = 3'd2,
      LOCKED = 3'd3,
      FAULT  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [LW-1:0] lock_q, lock_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          fault_q, fault_d;
   logic          pll_in_q, pll_in_d;
   logic          clean;
   logic          tracking;

`ifdef LOCK_HYST_EN
   localparam int UW = ($clog2(UNLOCK_CNT + 1) > 0) ? $clog2(UNLOCK_CNT + 1) : 1;
   localparam logic [UW-1:0] UNL_LAST = UW'(UNLOCK_CNT - 1);
   logic [UW-1:0] unl_q, unl_d;
`else
   logic unused_unlock;
   assign unused_unlock = ^UNLOCK_CNT;
`endif

   assign clean    = (bus.pll_err == 2'b00);
   assign tracking = (state_q == TRACK) || (state_q == LOCKED);

   always_comb begin
      state_d  = state_q;
      settle_d = '0;
      lock_d   = '0;
      tmo_d    = '0;
      retry_d  = retry_q;
      fault_d  = fault_q;
`ifdef LOCK_HYST_EN
      unl_d    = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.swiptAlive) begin
               state_d = LOAD;
               fault_d = 1'b0;
            end
         end
         LOAD: begin
            if (settle_q >= SETTLE_LAST) state_d = TRACK;
            else settle_d = settle_q + 1'b1;
         end
         TRACK: begin
            tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
            if (clean) lock_d = (lock_q == LOCK_MAX) ? lock_q : lock_q + 1'b1;
            // lock is checked first so it wins a same-cycle timeout
            if (clean && lock_q >= LOCK_LAST) begin
               state_d = LOCKED;
               lock_d  = '0;
               tmo_d   = '0;
               retry_d = '0;
            end else if (tmo_q >= TMO_LAST) begin
               lock_d = '0;
               tmo_d  = '0;
               if (retry_q >= RETRY_MAX) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end else begin
                  state_d = LOAD;
                  retry_d = retry_q + 1'b1;
                  fault_d = 1'b0;
               end
            end
         end
         LOCKED: begin
`ifdef LOCK_HYST_EN
            if (bus.pll_err[1]) begin
               if (unl_q >= UNL_LAST) state_d = TRACK;
               else unl_d = unl_q + 1'b1;
            end
`else
            if (bus.pll_err[1]) state_d = TRACK;
`endif
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // loss of link beats every other transition; fault stays sticky
      if (!bus.swiptAlive) begin
         state_d  = IDLE;
         settle_d = '0;
         lock_d   = '0;
         tmo_d    = '0;
         retry_d  = '0;
         fault_d  = fault_q;
`ifdef LOCK_HYST_EN
         unl_d    = '0;
`endif
      end
   end

   assign pll_in_d = tracking ? bus.pll_err[0] : bus.adc_comp;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         settle_q <= '0;
         lock_q   <= '0;
         tmo_q    <= '0;
         retry_q  <= '0;
         fault_q  <= 1'b0;
         pll_in_q <= 1'b0;
`ifdef LOCK_HYST_EN
         unl_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         lock_q   <= lock_d;
         tmo_q    <= tmo_d;
         retry_q  <= retry_d;
         fault_q  <= fault_d;
         pll_in_q <= pll_in_d;
`ifdef LOCK_HYST_EN
         unl_q    <= unl_d;
`endif
      end
   end

   assign bus.state     = state_q;
   assign bus.load_freq = !tracking;
   assign bus.locked    = (state_q == LOCKED);
   assign bus.fault     = fault_q;
   assign bus.pll_in    = pll_in_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed + random stimulus against a cycle-count reference model.
// Default parameters; define LOCK_HYST_EN for the hysteresis build.
module tb_pll_lock_ctrl;

   localparam int SETTLE = 256;
   localparam int LOCKN  = 64;
   localparam int TMO    = 4096;
   localparam int RETRY  = 3;
   localparam int UNLOCK = 4;

   localparam int S_IDLE   = 0;
   localparam int S_LOAD   = 1;
   localparam int S_TRACK  = 2;
   localparam int S_LOCKED = 3;
   localparam int S_FAULT  = 4;

   logic clk;
   logic nrst;
   pll_lock_ctrl_if bus ();

   pll_lock_ctrl #(
      .SETTLE_CYC (SETTLE),
      .LOCK_CNT   (LOCKN),
      .TRACK_TMO  (TMO),
      .MAX_RETRY  (RETRY),
      .UNLOCK_CNT (UNLOCK)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // reference model: how long we have been doing what
   int m_mode;
   int m_settle;
   int m_clean;
   int m_age;
   int m_retry;
   int m_slip;
   bit m_fault;
   bit m_pll_in;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = S_IDLE;
      m_settle = 0;
      m_clean  = 0;
      m_age    = 0;
      m_retry  = 0;
      m_slip   = 0;
      m_fault  = 0;
      m_pll_in = 0;
   endtask

   task automatic model_step(input logic alive, input logic adc,
                             input logic [1:0] err);
      int prev;
      prev = m_mode;
      m_pll_in = (prev == S_TRACK || prev == S_LOCKED) ? err[0] : adc;
      if (!alive) begin
         m_mode   = S_IDLE;
         m_retry  = 0;
         m_settle = 0;
         m_clean  = 0;
         m_age    = 0;
         m_slip   = 0;
         return;
      end
      case (prev)
         S_IDLE: begin
            m_mode   = S_LOAD;
            m_fault  = 0;
            m_settle = 0;
         end
         S_LOAD: begin
            m_settle++;
            if (m_settle == SETTLE) begin
               m_mode  = S_TRACK;
               m_clean = 0;
               m_age   = 0;
            end
         end
         S_TRACK: begin
            m_age++;
            m_clean = (err == 2'b00) ? m_clean + 1 : 0;
            if (m_clean == LOCKN) begin
               m_mode  = S_LOCKED;
               m_retry = 0;
               m_slip  = 0;
            end else if (m_age == TMO) begin
               if (m_retry == RETRY) begin
                  m_mode  = S_FAULT;
                  m_fault = 1;
               end else begin
                  m_retry++;
                  m_mode   = S_LOAD;
                  m_settle = 0;
                  m_fault  = 0;
               end
            end
         end
         S_LOCKED: begin
`ifdef LOCK_HYST_EN
            m_slip = err[1] ? m_slip + 1 : 0;
            if (m_slip == UNLOCK) begin
`else
            if (err[1]) begin
`endif
               m_mode  = S_TRACK;
               m_clean = 0;
               m_age   = 0;
               m_slip  = 0;
            end
         end
         default: m_mode = S_FAULT;
      endcase
   endtask

   task automatic compare_all();
      bit trk;
      trk = (m_mode == S_TRACK) || (m_mode == S_LOCKED);
      chk("state", bus.state, m_mode);
      chk("locked", bus.locked, m_mode == S_LOCKED);
      chk("load_freq", bus.load_freq, !trk);
      chk("fault", bus.fault, m_fault);
      chk("pll_in", bus.pll_in, m_pll_in);
   endtask

   task automatic tick(input logic alive, input logic adc,
                       input logic [1:0] err);
      bus.swiptAlive = alive;
      bus.adc_comp   = adc;
      bus.pll_err    = err;
      @(posedge clk);
      if (nrst) model_step(alive, adc, err);
      else model_reset();
      #1;
      compare_all();
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   int lat;
   logic lk;

   initial begin
      n_vec = 0;
      n_err = 0;
      nrst  = 1'b0;
      bus.swiptAlive = 1'b1;
      bus.adc_comp   = 1'b1;
      bus.pll_err    = 2'b00;
      model_reset();
      #3;
      compare_all();
      for (int i = 0; i < 3; i++) tick(1'b1, rbit(), 2'b00);
      nrst = 1'b1;

      // first acquisition: lock exactly 1+SETTLE+LOCKN edges after release
      lat = -1;
      for (int k = 1; k <= 330; k++) begin
         tick(1'b1, rbit(), 2'b00);
         if (lat < 0 && bus.locked === 1'b1) lat = k;
      end
      chk("lock_latency", lat, 1 + SETTLE + LOCKN);

      // single-cycle phase slip
      tick(1'b1, rbit(), 2'b10);
      lk = bus.locked;
`ifdef LOCK_HYST_EN
      chk("slip_pulse_locked", lk, 1'b1);
`else
      chk("slip_pulse_locked", lk, 1'b0);
`endif
      for (int k = 0; k < 70; k++) tick(1'b1, rbit(), 2'b00);
      chk("relock", bus.locked, 1'b1);
      for (int k = 0; k < UNLOCK; k++) tick(1'b1, rbit(), 2'b10);
      chk("slip_burst_locked", bus.locked, 1'b0);

      // link loss in LOCKED
      for (int k = 0; k < 70; k++) tick(1'b1, rbit(), 2'b00);
      chk("locked_before_drop", bus.locked, 1'b1);
      tick(1'b0, rbit(), 2'b00);
      chk("drop_state", bus.state, S_IDLE);
      chk("drop_locked", bus.locked, 1'b0);
      for (int k = 0; k < 8; k++) tick(1'b0, rbit(), 2'($urandom_range(0, 3)));

      // error at lock count LOCKN-1 restarts the run
      for (int k = 0; k < 1 + SETTLE + LOCKN - 1; k++)
         tick(1'b1, rbit(), 2'b00);
      chk("pre_err_state", bus.state, S_TRACK);
      tick(1'b1, rbit(), 2'b01);
      lat = -1;
      for (int k = 1; k <= 70; k++) begin
         tick(1'b1, rbit(), 2'b00);
         if (lat < 0 && bus.locked === 1'b1) lat = k;
      end
      chk("relock_latency", lat, LOCKN);

      // permanent error: all attempts time out, then FAULT
      tick(1'b0, rbit(), 2'b00);
      for (int k = 0; k < 1 + (RETRY + 1) * (SETTLE + TMO) + 10; k++)
         tick(1'b1, rbit(), 2'b01);
      chk("fault_flag", bus.fault, 1'b1);
      chk("fault_state", bus.state, S_FAULT);
      tick(1'b0, rbit(), 2'b01);
      chk("fault_idle_state", bus.state, S_IDLE);
      chk("fault_sticky", bus.fault, 1'b1);
      tick(1'b1, rbit(), 2'b01);
      chk("fault_clear_load", bus.fault, 1'b0);

      // asynchronous reset while tracking
      tick(1'b0, rbit(), 2'b00);
      for (int k = 0; k < 1 + SETTLE + 10; k++) tick(1'b1, rbit(), 2'b00);
      chk("pre_rst_state", bus.state, S_TRACK);
      #2;
      nrst = 1'b0;
      #1;
      model_reset();
      chk("async_rst_state", bus.state, S_IDLE);
      chk("async_rst_locked", bus.locked, 1'b0);
      compare_all();
      for (int k = 0; k < 3; k++) tick(1'b1, rbit(), 2'b00);
      nrst = 1'b1;

      // random soak
      for (int k = 0; k < 6000; k++) begin
         logic a;
         logic [1:0] e;
         a = ($urandom_range(0, 1999) != 0);
         e = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
         tick(a, rbit(), e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
